// File: rtl/imem_pkg.sv
// Shared types and helpers for the synchronous instruction-fetch memory.
// Used by the RTL and by the bench so both agree on byte order and fault encoding.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    RANGE    = 2'd1,
    MISALIGN = 2'd2
  } fault_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  // word arrives as {m[a+3], m[a+2], m[a+1], m[a]}; big selects m[a] as the MSB
  function automatic logic [31:0] byte_order(input logic [31:0] word, input logic big);
    if (big) begin
      return {word[7:0], word[15:8], word[23:16], word[31:24]};
    end
    return word;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Byte-organised instruction image with one registered 32-bit read port.
// The caller guarantees off..off+3 lies inside the image whenever en is high.
import imem_pkg::*;

module imem_array #(
  parameter int    DEPTH_BYTES = 4096,
  parameter int    BIG_BYTES   = 1,
  parameter string INIT_FILE   = "",
  localparam int   OFF_W       = $clog2(DEPTH_BYTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [OFF_W-1:0] off,
  output logic [31:0]      rdata
);

  logic [7:0]       mem [0:DEPTH_BYTES-1];
  logic [OFF_W-1:0] off1;
  logic [OFF_W-1:0] off2;
  logic [OFF_W-1:0] off3;

  assign off1 = off + OFF_W'(1);
  assign off2 = off + OFF_W'(2);
  assign off3 = off + OFF_W'(3);

  // Read register holds its value until the next enabled read, which keeps a
  // stalled response stable without a separate data register in the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= byte_order({mem[off3], mem[off2], mem[off1], mem[off]}, BIG_BYTES != 0);
    end
  end

endmodule

// File: rtl/imem_sync_fetch.sv
// Instruction memory front-end: valid/ready request and response, programmable wait
// states, range/alignment faults and flush. IMEM_HALFWORD_EN allows 2-byte-aligned fetch.
import imem_pkg::*;

module imem_sync_fetch #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'hBFC0_0000),
  parameter int                DEPTH_BYTES = 4096,
  parameter int                LATENCY     = 1,
  parameter int                BIG_BYTES   = 1,
  parameter string             INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_fault,
  output logic [1:0]        rsp_fault_cause,
  output imem_state_e       state
);

  // Handshake: a request transfers on a clock edge where req_valid && req_ready;
  // a response transfers where rsp_valid && rsp_ready. Neither side may retract
  // or change its payload while its valid is high and not yet taken.

  localparam int                OFF_W    = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(DEPTH_BYTES - 4);
  localparam logic [3:0]        LAT_LOAD = 4'(LATENCY - 1);

  imem_state_e       cur_state;
  imem_state_e       next_state;
  logic [3:0]        cnt;
  logic [3:0]        cnt_next;
  logic              alive;
  logic              accept;
  logic [ADDR_W-1:0] off;
  fault_e            req_fault;
  logic [ADDR_W-1:0] addr_q;
  fault_e            fault_q;
  logic [31:0]       arr_rdata;

  assign off = req_addr - BASE_ADDR;

  // Range is checked before alignment so an out-of-image address reports RANGE.
  always_comb begin
    req_fault = NONE;
    if (off > LAST_OFF) begin
      req_fault = RANGE;
`ifdef IMEM_HALFWORD_EN
    end else if (off[0]) begin
      req_fault = MISALIGN;
`else
    end else if (off[1:0] != 2'b00) begin
      req_fault = MISALIGN;
`endif
    end
  end

  always_comb begin
    next_state = cur_state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    accept     = 1'b0;

    // alive keeps req_ready low while reset is held and until the first clock after it.
    case (cur_state)
      IDLE:    req_ready = alive && !flush;
      WAIT:    req_ready = 1'b0;
      RESP:    req_ready = rsp_ready && !flush;
      default: req_ready = 1'b0;
    endcase
    accept = req_valid && req_ready;

    if (flush) begin
      next_state = IDLE;
      cnt_next   = '0;
    end else if (accept) begin
      if (LATENCY == 1) begin
        next_state = RESP;
      end else begin
        next_state = WAIT;
        cnt_next   = LAT_LOAD;
      end
    end else begin
      case (cur_state)
        WAIT: begin
          if (cnt == 4'd1) begin
            next_state = RESP;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            next_state = IDLE;
          end
        end
        default: next_state = cur_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      cnt       <= '0;
      alive     <= 1'b0;
      addr_q    <= '0;
      fault_q   <= NONE;
    end else begin
      cur_state <= next_state;
      cnt       <= cnt_next;
      alive     <= 1'b1;
      if (accept) begin
        addr_q  <= req_addr;
        fault_q <= req_fault;
      end
    end
  end

  // Faulted requests never touch the array, so no out-of-image index is formed.
  imem_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .BIG_BYTES   (BIG_BYTES),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept && (req_fault == NONE)),
    .off   (off[OFF_W-1:0]),
    .rdata (arr_rdata)
  );

  assign rsp_valid       = (cur_state == RESP);
  assign rsp_addr        = addr_q;
  assign rsp_fault       = (fault_q != NONE);
  assign rsp_fault_cause = fault_q;
  assign rsp_rdata       = (fault_q != NONE) ? NOP_INSTR : arr_rdata;
  assign state           = cur_state;

endmodule

// File: tb/tb_imem_sync_fetch.sv
// Bench for imem_sync_fetch: two instances (LATENCY 1 big-endian, LATENCY 3 little-endian)
// driven by directed tasks and a randomized transaction-level reference model.
import imem_pkg::*;

module tb_imem_sync_fetch;

  localparam logic [31:0] BASE  = 32'hBFC0_0000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n           [2];
  logic        flush           [2];
  logic        req_valid       [2];
  logic        req_ready       [2];
  logic [31:0] req_addr        [2];
  logic        rsp_valid       [2];
  logic        rsp_ready       [2];
  logic [31:0] rsp_rdata       [2];
  logic [31:0] rsp_addr        [2];
  logic        rsp_fault       [2];
  logic [1:0]  rsp_fault_cause [2];
  imem_state_e state           [2];

  logic [7:0]  img [0:DEPTH-1];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  imem_sync_fetch #(
    .ADDR_W(32), .BASE_ADDR(BASE), .DEPTH_BYTES(DEPTH),
    .LATENCY(1), .BIG_BYTES(1), .INIT_FILE("")
  ) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .flush(flush[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_addr(rsp_addr[0]), .rsp_fault(rsp_fault[0]),
    .rsp_fault_cause(rsp_fault_cause[0]), .state(state[0])
  );

  imem_sync_fetch #(
    .ADDR_W(32), .BASE_ADDR(BASE), .DEPTH_BYTES(DEPTH),
    .LATENCY(3), .BIG_BYTES(0), .INIT_FILE("")
  ) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .flush(flush[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_addr(rsp_addr[1]), .rsp_fault(rsp_fault[1]),
    .rsp_fault_cause(rsp_fault_cause[1]), .state(state[1])
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic big_of(input int i);
    return (i == 0);
  endfunction

  // Reference: fault cause from the address rules alone.
  function automatic logic [1:0] exp_cause(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (off > 32'(DEPTH - 4)) return 2'd1;
`ifdef IMEM_HALFWORD_EN
    if (off % 2 != 0) return 2'd2;
`else
    if (off % 4 != 0) return 2'd2;
`endif
    return 2'd0;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] addr, input logic big);
    int o;
    if (exp_cause(addr) != 2'd0) return NOP_INSTR;
    o = int'(addr - BASE);
    return byte_order({img[o+3], img[o+2], img[o+1], img[o]}, big);
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: return BASE + 32'(4 * $urandom_range(0, DEPTH / 4 - 1));
      5:             return BASE + 32'($urandom_range(0, DEPTH - 1));
      6:             return BASE + 32'(DEPTH) + 32'($urandom_range(0, 15));
      7:             return BASE - 32'(4 * $urandom_range(1, 4));
      default:       return BASE + 32'(DEPTH - 8) + 32'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_rsp(input int i, input logic [31:0] addr);
    logic [1:0] ec;
    ec = exp_cause(addr);
    check("rsp_valid", 32'(rsp_valid[i]), 32'd1);
    check("rsp_rdata", rsp_rdata[i], exp_data(addr, big_of(i)));
    check("rsp_addr", rsp_addr[i], addr);
    check("rsp_fault", 32'(rsp_fault[i]), 32'(ec != 2'd0));
    check("rsp_cause", 32'(rsp_fault_cause[i]), 32'(ec));
  endtask

  // Single request from idle: checks latency, payload, and stability under hold cycles of backpressure.
  task automatic do_req(input int i, input logic [31:0] addr, input int hold);
    int cyc;
    @(posedge clk); #1;
    req_valid[i] = 1'b1; req_addr[i] = addr; rsp_ready[i] = 1'b0; #1;
    check("req_ready_idle", 32'(req_ready[i]), 32'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0; req_addr[i] = $urandom;
    cyc = 1;
    while (!rsp_valid[i] && cyc < 40) begin
      check("req_ready_wait", 32'(req_ready[i]), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(lat_of(i)));
    for (int h = 0; h <= hold; h++) begin
      check_rsp(i, addr);
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
    check("rsp_drop", 32'(rsp_valid[i]), 32'd0);
  endtask

  task automatic back_to_back();
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_addr[0] = BASE + 32'd12; rsp_ready[0] = 1'b0;
    @(posedge clk); #1;
    check_rsp(0, BASE + 32'd12);
    rsp_ready[0] = 1'b1; req_addr[0] = BASE + 32'd16; #1;
    check("b2b_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check_rsp(0, BASE + 32'd16);
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    check("b2b_drain", 32'(rsp_valid[0]), 32'd0);
  endtask

  task automatic flush_test();
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_addr[1] = BASE + 32'd20;
    @(posedge clk); #1;
    flush[1] = 1'b1; #1;
    check("flush_wait_ready", 32'(req_ready[1]), 32'd0);
    @(posedge clk); #1;
    flush[1] = 1'b0; req_valid[1] = 1'b0; #1;
    check("flush_state", 32'(state[1]), 32'(IDLE));
    check("flush_valid", 32'(rsp_valid[1]), 32'd0);
    check("flush_ready", 32'(req_ready[1]), 32'd1);
    flush[1] = 1'b1; req_valid[1] = 1'b1; #1;
    check("flush_blocks_accept", 32'(req_ready[1]), 32'd0);
    @(posedge clk); #1;
    flush[1] = 1'b0; req_valid[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("flush_no_rsp", 32'(rsp_valid[1]), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic async_reset_test();
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_addr[0] = BASE + 32'd4; rsp_ready[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("ar_pre_valid", 32'(rsp_valid[0]), 32'd1);
    #2 rst_n[0] = 1'b0;
    #1;
    check("ar_valid", 32'(rsp_valid[0]), 32'd0);
    check("ar_ready", 32'(req_ready[0]), 32'd0);
    check("ar_addr", rsp_addr[0], 32'd0);
    check("ar_rdata", rsp_rdata[0], 32'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
  endtask

  // Transaction-level model: one outstanding response, visible lat cycles after acceptance.
  task automatic run_random(input int i, input int n);
    bit          busy = 1'b0;
    int          t = 0;
    logic [31:0] e_addr = '0;
    logic [31:0] a;
    bit          rv, rr, fl, exp_ready, exp_valid;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rv = ($urandom_range(0, 2) != 0);
      rr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 24) == 0);
      a  = pick_addr();
      req_valid[i] = rv; req_addr[i] = a; rsp_ready[i] = rr; flush[i] = fl; #1;
      exp_valid = busy && (t == 0);
      exp_ready = !fl && (!busy || (exp_valid && rr));
      check("rnd_req_ready", 32'(req_ready[i]), 32'(exp_ready));
      check("rnd_rsp_valid", 32'(rsp_valid[i]), 32'(exp_valid));
      if (exp_valid) check_rsp(i, e_addr);
      if (fl) begin
        busy = 1'b0;
      end else begin
        if (exp_valid && rr) busy = 1'b0;
        if (rv && exp_ready) begin
          busy = 1'b1; t = lat_of(i) - 1; e_addr = a;
        end else if (busy && t > 0) begin
          t--;
        end
      end
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0; rsp_ready[i] = 1'b0; flush[i] = 1'b1;
    @(posedge clk); #1;
    flush[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; flush[i] = 1'b0; req_valid[i] = 1'b0;
      req_addr[i] = '0; rsp_ready[i] = 1'b0;
    end
    for (int j = 0; j < DEPTH; j++) img[j] = 8'($urandom);
    img[0] = 8'h00; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h93;
    for (int j = 0; j < DEPTH; j++) begin
      dut0.u_array.mem[j] = img[j];
      dut1.u_array.mem[j] = img[j];
    end

    #1;
    check("rst_req_ready0", 32'(req_ready[0]), 32'd0);
    check("rst_req_ready1", 32'(req_ready[1]), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_rdata", rsp_rdata[0], 32'd0);
    check("rst_addr", rsp_addr[0], 32'd0);
    check("rst_fault", 32'(rsp_fault[0]), 32'd0);
    check("rst_cause", 32'(rsp_fault_cause[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(req_ready[0]), 32'd1);

    do_req(0, BASE, 0);
    check("basic_word", exp_data(BASE, 1'b1), 32'h0000_0093);
    do_req(0, BASE + 32'd8, 4);
    back_to_back();
    do_req(1, BASE + 32'd4, 0);
    do_req(1, BASE + 32'd40, 2);

    do_req(0, BASE + 32'(DEPTH), 0);
    do_req(0, BASE + 32'd2, 1);
    do_req(0, BASE + 32'd1, 0);
    do_req(0, BASE + 32'(DEPTH - 4), 0);
    do_req(0, BASE + 32'(DEPTH - 3), 0);
    do_req(1, BASE + 32'd2, 0);
    do_req(1, BASE - 32'd4, 0);

    flush_test();
    async_reset_test();

    run_random(0, 300);
    run_random(1, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
